// File: rtl/mp_regfile_pkg.sv
// Shared defines for the multi-ported register file: default geometry,
// the all-zero word and the active level of the enable inputs.
package mp_regfile_pkg;

   localparam int DEF_XLEN = 32;
   localparam int DEF_NREG = 32;
   localparam int DEF_NRD  = 2;
   localparam int DEF_NWR  = 2;

   localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

   localparam logic EN_ACTIVE = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracker: one bit per register, set by issue, cleared by writeback.
// A set and a clear of the same register in one cycle leaves it busy.
module regfile_scoreboard
   import mp_regfile_pkg::*;
#(
   parameter int NREG = DEF_NREG
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     set_en,
   input  logic [$clog2(NREG)-1:0]  set_addr,
   input  logic [NREG-1:0]          clr_vec,
   output logic [NREG-1:0]          busy_vec
);

   logic [NREG-1:0] busy_nxt;

   // Set is applied after the clear so it wins on a same-register collision.
   always_comb begin
      busy_nxt = busy_vec & ~clr_vec;
      if (set_en == EN_ACTIVE && set_addr != '0) begin
         busy_nxt[set_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_vec <= '0;
      end else if (rdy) begin
         busy_vec <= busy_nxt;
      end
   end

endmodule

// File: rtl/mp_regfile.sv
// Multi-ported register file with busy scoreboard. Define MP_REGFILE_BYPASS_EN
// to forward same-cycle write data and post-update busy state to the read ports.
module mp_regfile
   import mp_regfile_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int NREG = DEF_NREG,
   parameter int NRD  = DEF_NRD,
   parameter int NWR  = DEF_NWR
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic [NRD-1:0]                re,
   input  logic [NRD*$clog2(NREG)-1:0]   raddr,
   output logic [NRD*XLEN-1:0]           rdata,
   output logic [NRD-1:0]                rbusy,
   input  logic [NWR-1:0]                we,
   input  logic [NWR*$clog2(NREG)-1:0]   waddr,
   input  logic [NWR*XLEN-1:0]           wdata,
   input  logic                          set_en,
   input  logic [$clog2(NREG)-1:0]       set_addr,
   output logic [NREG-1:0]               busy_vec
);

   localparam int AW = $clog2(NREG);
   localparam logic [XLEN-1:0] ZW = XLEN'(ZERO_WORD);

   // rdy is a global qualifier, not a handshake: state advances only on edges
   // where rdy=1, and there is no back-pressure from this block.
   logic [XLEN-1:0] mem [NREG];
   logic [NREG-1:0] wr_hit;
   logic [XLEN-1:0] wr_data [NREG];

   // Per-register write decode; later ports overwrite earlier ones on collision.
   always_comb begin
      wr_hit = '0;
      for (int r = 0; r < NREG; r++) begin
         wr_data[r] = ZW;
      end
      for (int j = 0; j < NWR; j++) begin
         if (we[j] == EN_ACTIVE && waddr[j*AW +: AW] != '0) begin
            wr_hit[waddr[j*AW +: AW]]  = 1'b1;
            wr_data[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            mem[r] <= ZW;
         end
      end else if (rdy) begin
         for (int r = 0; r < NREG; r++) begin
            if (wr_hit[r]) begin
               mem[r] <= wr_data[r];
            end
         end
      end
   end

   regfile_scoreboard #(.NREG(NREG)) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .set_en   (set_en),
      .set_addr (set_addr),
      .clr_vec  (wr_hit),
      .busy_vec (busy_vec)
   );

`ifdef MP_REGFILE_BYPASS_EN
   logic [NREG-1:0] busy_post;

   always_comb begin
      busy_post = busy_vec & ~wr_hit;
      if (set_en == EN_ACTIVE && set_addr != '0) begin
         busy_post[set_addr] = 1'b1;
      end
   end
`endif

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            rb;

      assign ra = raddr[i*AW +: AW];

      always_comb begin
         rd = mem[ra];
         rb = busy_vec[ra];
`ifdef MP_REGFILE_BYPASS_EN
         if (rdy && wr_hit[ra]) begin
            rd = wr_data[ra];
            rb = busy_post[ra];
         end
`endif
         if (rst || re[i] != EN_ACTIVE || ra == '0) begin
            rd = ZW;
            rb = 1'b0;
         end
      end

      assign rdata[i*XLEN +: XLEN] = rd;
      assign rbusy[i]              = rb;
   end

endmodule

// File: tb/tb_mp_regfile.sv
// Bench for mp_regfile: directed vectors with literal expectations plus a
// per-cycle comparison against an array model of the register file.
module tb_mp_regfile;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic                  clk;
   logic                  rst;
   logic                  rdy;
   logic [NRD-1:0]        re;
   logic [NRD*AW-1:0]     raddr;
   logic [NRD*XLEN-1:0]   rdata;
   logic [NRD-1:0]        rbusy;
   logic [NWR-1:0]        we;
   logic [NWR*AW-1:0]     waddr;
   logic [NWR*XLEN-1:0]   wdata;
   logic                  set_en;
   logic [AW-1:0]         set_addr;
   logic [NREG-1:0]       busy_vec;

   int errors = 0;
   int checks = 0;

   mp_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .re       (re),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .set_en   (set_en),
      .set_addr (set_addr),
      .busy_vec (busy_vec)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [XLEN-1:0] model_mem [NREG];
   logic [NREG-1:0] model_busy;
   bit              model_ok = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) model_mem[r] = '0;
         model_busy = '0;
         model_ok   = 1;
      end else if (rdy) begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && waddr[j*AW +: AW] != 0) begin
               model_mem[waddr[j*AW +: AW]]  = wdata[j*XLEN +: XLEN];
               model_busy[waddr[j*AW +: AW]] = 1'b0;
            end
         end
         if (set_en && set_addr != 0) model_busy[set_addr] = 1'b1;
      end
   end

   function automatic void exp_rd(input int i, output logic [XLEN-1:0] d, output logic b);
      logic [AW-1:0] a;
      a = raddr[i*AW +: AW];
      d = model_mem[a];
      b = model_busy[a];
`ifdef MP_REGFILE_BYPASS_EN
      if (rdy) begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && waddr[j*AW +: AW] == a && a != 0) begin
               d = wdata[j*XLEN +: XLEN];
               b = set_en && set_addr == a;
            end
         end
      end
`endif
      if (rst || !re[i] || a == 0) begin
         d = '0;
         b = 1'b0;
      end
   endfunction

   always @(negedge clk) begin
      if (model_ok) begin
         for (int i = 0; i < NRD; i++) begin
            logic [XLEN-1:0] d;
            logic            b;
            exp_rd(i, d, b);
            chk($sformatf("model_rdata%0d", i), 64'(rdata[i*XLEN +: XLEN]), 64'(d));
            chk($sformatf("model_rbusy%0d", i), 64'(rbusy[i]), 64'(b));
         end
         chk("model_busy_vec", 64'(busy_vec), 64'(model_busy));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      we     = '0;
      set_en = 1'b0;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic set_rd(input int i, input logic [AW-1:0] a);
      raddr[i*AW +: AW] = a;
   endtask

   task automatic drive_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      we[j]                  = 1'b1;
      waddr[j*AW +: AW]      = a;
      wdata[j*XLEN +: XLEN]  = d;
   endtask

   task automatic drive_set(input logic [AW-1:0] a);
      set_en   = 1'b1;
      set_addr = a;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; rdy = 1'b1; re = '1; raddr = '0;
      we = '0; waddr = '0; wdata = '0; set_en = 1'b0; set_addr = '0;

      repeat (2) @(posedge clk);
      #1;
      set_rd(0, 5); set_rd(1, 5);
      look();
      chk("rst_rdata0", 64'(rdata[31:0]), 64'h0);
      chk("rst_busy_vec", 64'(busy_vec), 64'h0);

      tick(); rst = 1'b0;
      look();
      chk("reset_rdata5_p0", 64'(rdata[31:0]), 64'h0);
      chk("reset_rdata5_p1", 64'(rdata[63:32]), 64'h0);
      chk("reset_rbusy", 64'(rbusy), 64'h0);

      // Write/read same cycle
      tick(); drive_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3);
      look();
`ifdef MP_REGFILE_BYPASS_EN
      chk("same_cycle_rd3", 64'(rdata[31:0]), 64'hDEADBEEF);
`else
      chk("same_cycle_rd3", 64'(rdata[31:0]), 64'h0);
`endif
      tick(); look();
      chk("next_cycle_rd3", 64'(rdata[31:0]), 64'hDEADBEEF);

      // Write-port collision: highest index wins
      tick(); drive_wr(0, 7, 32'h11); drive_wr(1, 7, 32'h22); set_rd(1, 7);
      tick(); look();
      chk("collision_rd7", 64'(rdata[63:32]), 64'h22);

      // Busy set, set+clear, clear
      tick(); drive_set(9); set_rd(0, 9);
      tick(); look();
      chk("busy9_set", 64'(busy_vec[9]), 64'h1);
      chk("rbusy9_set", 64'(rbusy[0]), 64'h1);
      tick(); drive_set(9); drive_wr(0, 9, 32'h99);
      look();
      chk("rbusy9_set_and_wr", 64'(rbusy[0]), 64'h1);
      tick(); look();
      chk("busy9_set_wins", 64'(busy_vec[9]), 64'h1);
      chk("rd9_after_wr", 64'(rdata[31:0]), 64'h99);
      tick(); drive_wr(0, 9, 32'h9A);
      look();
`ifdef MP_REGFILE_BYPASS_EN
      chk("rbusy9_clearing", 64'(rbusy[0]), 64'h0);
`else
      chk("rbusy9_clearing", 64'(rbusy[0]), 64'h1);
`endif
      tick(); look();
      chk("busy9_cleared", 64'(busy_vec[9]), 64'h0);

      // Register 0 is immutable
      tick(); drive_wr(0, 0, 32'h55); drive_set(0); set_rd(0, 0);
      look();
      chk("r0_same_cycle", 64'(rdata[31:0]), 64'h0);
      tick(); look();
      chk("r0_rdata", 64'(rdata[31:0]), 64'h0);
      chk("r0_busy", 64'(busy_vec[0]), 64'h0);

      // rdy=0 freezes state and suppresses bypass
      tick(); drive_wr(0, 4, 32'h44);
      tick(); rdy = 1'b0; drive_wr(0, 4, 32'hAA); drive_set(4); set_rd(0, 4);
      look();
      chk("stall_same_cycle_rd4", 64'(rdata[31:0]), 64'h44);
      tick(); rdy = 1'b1;
      look();
      chk("stall_rd4", 64'(rdata[31:0]), 64'h44);
      chk("stall_busy4", 64'(busy_vec[4]), 64'h0);

      // re=0 forces zero
      re[1] = 1'b0; set_rd(1, 7);
      look();
      chk("re0_rdata1", 64'(rdata[63:32]), 64'h0);
      re[1] = 1'b1;

      // Reset discards pending sets and same-cycle writes
      tick(); drive_set(12);
      tick(); drive_set(13); drive_wr(0, 20, 32'h77); rst = 1'b1; set_rd(0, 20);
      look();
      chk("rst_rdata_p0", 64'(rdata[31:0]), 64'h0);
      tick(); rst = 1'b0;
      look();
      chk("rst_clears_busy", 64'(busy_vec), 64'h0);
      chk("rst_discards_wr20", 64'(rdata[31:0]), 64'h0);
      chk("rst_clears_rd7", 64'(rdata[63:32]), 64'h0);

      // Randomised traffic on a narrow address range, checked by the model
      for (int n = 0; n < 60; n++) begin
         tick();
         rst = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 7) != 0);
         for (int j = 0; j < NWR; j++) begin
            if ($urandom_range(0, 1) == 1) drive_wr(j, AW'($urandom_range(0, 7)), $urandom);
         end
         if ($urandom_range(0, 2) == 0) drive_set(AW'($urandom_range(0, 7)));
         for (int i = 0; i < NRD; i++) begin
            re[i] = ($urandom_range(0, 5) != 0);
            set_rd(i, AW'($urandom_range(0, 7)));
         end
      end
      tick(); rst = 1'b0; rdy = 1'b1;
      look();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mp_regfile.md
MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 SHALL have parameter XLEN, 32, data width in bits.
REQ-002 SHALL have parameter NREG, 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, 2, number of read ports (>=1).
REQ-004 SHALL have parameter NWR, 2, number of write ports (>=1).
REQ-005 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-008 SHALL have port re  input  NRD  per-read-port enable.
REQ-009 SHALL have port raddr  input  NRD*AW  read addresses, port i in slice i.
REQ-010 SHALL have port rdata  output  NRD*XLEN  read data, port i in slice i.
REQ-011 SHALL have port rbusy  output  NRD  pending-write flag of addressed register.
REQ-012 SHALL have port we  input  NWR  per-write-port enable.
REQ-013 SHALL have port waddr  input  NWR*AW  write addresses.
REQ-014 SHALL have port wdata  input  NWR*XLEN  write data.
REQ-015 SHALL have port set_en  input  1  issue marks destination busy.
REQ-016 SHALL have port set_addr  input  AW  destination register to mark busy.
REQ-017 SHALL have port busy_vec  output  NREG  registered busy bits, bit r = register r.

Function
REQ-018 Register 0 SHALL always read 0, never be written, never be busy; writes/sets to 0 ignored.
REQ-019 Write: on rising edge with rdy=1, rst=0, we[j]=1, waddr[j]!=0, array[waddr[j]] <= wdata[j].
REQ-020 Same-address collision between write ports SHALL resolve to highest port index.
REQ-021 Busy bit r SHALL be cleared on an accepted write to r (any port) and set by accepted set_en with set_addr=r.
REQ-022 Same-cycle set and clear of same register SHALL leave it busy (set wins).
REQ-023 Read ports SHALL be combinational, zero latency; re[i]=0 forces rdata slice i and rbusy[i] to 0.
REQ-024 With rdy=0 all array and busy state SHALL hold; read outputs SHALL still reflect current state.
REQ-025 Out-of-range conditions do not exist (AW exact); all NREG entries SHALL be addressable.

Reset
REQ-026 rst=1 at a rising edge SHALL clear every array entry and every busy bit to 0, overriding rdy, we and set_en.
REQ-027 While rst=1 all rdata and rbusy outputs SHALL be 0; busy_vec SHALL be 0 from the first edge after rst asserts.
REQ-028 Reset mid-operation SHALL discard same-cycle writes and sets.

Configuration
REQ-029 Macro MP_REGFILE_BYPASS_EN defined: a read of a register being written this cycle SHALL return that wdata (highest write port) and rbusy SHALL reflect post-update value (0 unless also set this cycle).
REQ-030 MP_REGFILE_BYPASS_EN undefined: reads SHALL return stored array value and registered busy bit only; same-cycle write visible next cycle.
REQ-031 Bypass SHALL apply only when rdy=1 and rst=0; register 0 SHALL never bypass.

Structure
REQ-032 Default XLEN/NREG values, ZeroWord and enable-level constants SHALL reside in the shared defines package.
REQ-033 Busy-bit tracking SHALL be a sub-module named regfile_scoreboard (set/clear/busy_vec); array and bypass muxes stay in mp_regfile.

Verification
REQ-034 Reset then read all ports addr 5 -> rdata=0, rbusy=0, busy_vec=0.
REQ-035 we[0]=1 waddr=3 wdata=0xDEADBEEF, read addr 3 same cycle -> 0xDEADBEEF with bypass, old value without; next cycle 0xDEADBEEF both.
REQ-036 we[0],we[1] both addr 7, data 0x11/0x22 -> addr 7 reads 0x22.
REQ-037 set_en addr 9 -> busy_vec[9]=1 next cycle; same-cycle set+write addr 9 -> stays 1; later write addr 9 -> clears.
REQ-038 write 0x55 to addr 0 plus set_en addr 0 -> reads 0, busy_vec[0]=0.
REQ-039 rdy=0 with write addr 4 0xAA -> addr 4 unchanged; rst during pending set -> busy_vec=0.
